calendar_ctrl: RTL and testbench
================================

Name: calendar_ctrl

Overview:
- Sequences the day counter: generates its one-cycle advance enable, routes user up/down presses, and supplies the month-class selects TO/T/TN and leap_year.
- Owns the BCD month (01-12) and year (00-99, i.e. 2000-2099) counters and the user set-mode FSM.
- After a month or year edit, clamps an out-of-range day down to the new month length.
- Sits between the time-of-day chain (hour rollover tick) and the day counter, feeding display digits.

Parameters:
- RESET_MONTH, 1, month loaded at reset (binary 1-12, stored as BCD)
- RESET_YEAR, 0, year-in-century loaded at reset (binary 0-99, stored as BCD)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- tick_day  in  1  one-cycle pulse on hour 23->00 rollover
- pulse_d  in  1  day-counter month-rollover pulse, coincident with en_d
- btn_mode  in  1  debounced one-cycle press
- btn_up  in  1  debounced one-cycle press
- btn_down  in  1  debounced one-cycle press
- day_unit  in  4  current day BCD unit
- day_ten  in  2  current day BCD ten
- en_d  out  1  day advance enable, one cycle
- up  out  1  day increment request, one cycle
- down  out  1  day decrement request, one cycle
- TO  out  1  month has 31 days
- T  out  1  month has 30 days
- TN  out  1  month is February
- leap_year  out  1  current year is leap
- month_unit  out  4  BCD
- month_ten  out  1  BCD
- year_unit  out  4  BCD
- year_ten  out  4  BCD
- mode  out  2  0 RUN, 1 SET_DAY, 2 SET_MONTH, 3 SET_YEAR
- pulse_y  out  1  one cycle on year 99->00 in RUN (century carry)

Behaviour:
- Reset (rst_n low at clk edge): state RUN, month/year = RESET_MONTH/RESET_YEAR, en_d/up/down/pulse_y = 0; decodes follow from registers.
- Decode, combinational from registers; exactly one of TO/T/TN is high at all times:
  - TO for months 1,3,5,7,8,10,12; T for 4,6,9,11; TN for 2.
  - leap_year = (year_ten even and year_unit in {0,4,8}) or (year_ten odd and year_unit in {2,6}).
  - maxday = 31, 30, 29 (TN and leap) or 28.
- FSM states: RUN, SET_DAY, SET_MONTH, SET_YEAR, CLAMP_CHK, CLAMP_WAIT.
- btn_mode cycles RUN->SET_DAY->SET_MONTH->SET_YEAR->RUN. It wins over btn_up/btn_down in the same cycle and is ignored in the CLAMP states.
- RUN:
  - en_d = tick_day (combinational pass, zero latency); up = down = 0.
  - On pulse_d, month increments at that edge; 12->01 also increments year; year 99->00 asserts pulse_y the next cycle.
- SET_DAY: up = btn_up & ~btn_down; down = btn_down & ~btn_up; both pressed = no action; en_d = 0.
- SET_MONTH: up/down presses move the month with wrap 12<->01; year unaffected. Each change enters CLAMP_CHK.
- SET_YEAR: up/down presses move the year with wrap 99<->00; no pulse_y. Each change enters CLAMP_CHK.
- Clamp sequence:
  - CLAMP_CHK: if day (ten*10+unit) > maxday, assert down for one cycle and go to CLAMP_WAIT; else return to the originating set state.
  - CLAMP_WAIT: one idle cycle so the day counter updates, then CLAMP_CHK.
  - Worst case 31->28 takes 3 down pulses, 7 cycles.
  - btn_up/btn_down are ignored during clamp.
- Outside RUN, tick_day is dropped (see optional feature).
- Outputs up/down/en_d are never high together.

Optional Feature:
- Macro CAL_TICK_HOLD_EN.
- Defined: a tick_day arriving outside RUN sets a one-deep pending flag (further ticks are lost). On the first RUN cycle, en_d is asserted from the flag instead of tick_day, and the flag clears. A live tick in that same cycle also sets the flag again, to be delivered next cycle. Reset clears the flag.
- Undefined: ticks outside RUN are discarded.

Decomposition:
- cal_pkg: mode/state encodings, BCD month constants, maxday constants 31/30/29/28.
- One sub-module, cal_decode: combinational month/year BCD -> TO, T, TN, leap_year, maxday; instanced once.

Test Plan:
- Reset with defaults -> month 01, year 00, TO=1, leap_year=1, mode 0, all pulses 0.
- RUN, month 02, year 23, day 28, tick_day -> en_d same cycle; with pulse_d, month becomes 03 and TN->0, TO->1.
- RUN, month 12, year 99, pulse_d -> month 01, year 00, pulse_y high exactly one cycle.
- SET_MONTH, month 01, day 31, year 21, btn_up -> month 02; down pulses on 3 non-adjacent cycles; returns to SET_MONTH with day 28.
- SET_YEAR, day 29 Feb, year 24, btn_up -> year 25, one down pulse; btn_down from 00 -> 99 with no pulse_y.
- Same-cycle btn_mode+btn_up in SET_DAY -> mode 2, up stays 0. With CAL_TICK_HOLD_EN, tick in SET_YEAR then mode -> en_d on the first RUN cycle.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared definitions for the calendar controller slice.
// Holds the FSM state and display-mode encodings, the BCD month constants,
// the month-length constants and the BCD month/year step helpers.
package cal_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_DAY,
    ST_SET_MONTH,
    ST_SET_YEAR,
    ST_CLAMP_CHK,
    ST_CLAMP_WAIT
  } state_e;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_DAY   = 2'd1,
    MODE_SET_MONTH = 2'd2,
    MODE_SET_YEAR  = 2'd3
  } mode_e;

  // Month is held as {ten, unit} BCD in 5 bits.
  localparam logic [4:0] MON_JAN = 5'h01;
  localparam logic [4:0] MON_FEB = 5'h02;
  localparam logic [4:0] MON_OCT = 5'h10;
  localparam logic [4:0] MON_DEC = 5'h12;

  localparam logic [5:0] MAXDAY_31 = 6'd31;
  localparam logic [5:0] MAXDAY_30 = 6'd30;
  localparam logic [5:0] MAXDAY_29 = 6'd29;
  localparam logic [5:0] MAXDAY_28 = 6'd28;

  function automatic logic [7:0] bin2bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [4:0] month_inc(input logic [4:0] m);
    if (m == MON_DEC) return MON_JAN;
    if (m[3:0] == 4'd9) return MON_OCT;
    return m + 5'd1;
  endfunction

  function automatic logic [4:0] month_dec(input logic [4:0] m);
    if (m == MON_JAN) return MON_DEC;
    if (m == MON_OCT) return 5'h09;
    return m - 5'd1;
  endfunction

  function automatic logic [7:0] year_inc(input logic [7:0] y);
    if (y == 8'h99) return 8'h00;
    if (y[3:0] == 4'd9) return {y[7:4] + 4'd1, 4'd0};
    return y + 8'd1;
  endfunction

  function automatic logic [7:0] year_dec(input logic [7:0] y);
    if (y == 8'h00) return 8'h99;
    if (y[3:0] == 4'd0) return {y[7:4] - 4'd1, 4'd9};
    return y - 8'd1;
  endfunction

endpackage

// File: rtl/calendar_ctrl_if.sv
// Signal bundle between the calendar controller and its neighbours
// (time-of-day tick, buttons, day counter, display).
//   master : the calendar controller (drives en_d/up/down, decodes, digits)
//   slave  : the surrounding logic (drives tick, buttons, day digits)
interface calendar_ctrl_if;
  logic       tick_day;
  logic       pulse_d;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] day_unit;
  logic [1:0] day_ten;
  logic       en_d;
  logic       up;
  logic       down;
  logic       TO;
  logic       T;
  logic       TN;
  logic       leap_year;
  logic [3:0] month_unit;
  logic       month_ten;
  logic [3:0] year_unit;
  logic [3:0] year_ten;
  logic [1:0] mode;
  logic       pulse_y;

  modport master (
    input  tick_day, pulse_d, btn_mode, btn_up, btn_down, day_unit, day_ten,
    output en_d, up, down, TO, T, TN, leap_year,
           month_unit, month_ten, year_unit, year_ten, mode, pulse_y
  );

  modport slave (
    output tick_day, pulse_d, btn_mode, btn_up, btn_down, day_unit, day_ten,
    input  en_d, up, down, TO, T, TN, leap_year,
           month_unit, month_ten, year_unit, year_ten, mode, pulse_y
  );
endinterface

// File: rtl/cal_decode.sv
// Combinational month/year decode.
// Inputs : month_unit_i/month_ten_i (BCD 01-12), year_unit_i/year_ten_i (BCD 00-99)
// Outputs: to_o (31-day month), t_o (30-day month), tn_o (February),
//          leap_o (leap year within 2000-2099), maxday_o (days in month)
// Exactly one of to_o/t_o/tn_o is high; unexpected month codes read as 31-day.
module cal_decode
  import cal_pkg::*;
(
  input  logic [3:0] month_unit_i,
  input  logic       month_ten_i,
  input  logic [3:0] year_unit_i,
  input  logic [3:0] year_ten_i,
  output logic       to_o,
  output logic       t_o,
  output logic       tn_o,
  output logic       leap_o,
  output logic [5:0] maxday_o
);

  always_comb begin
    to_o = 1'b1;
    t_o  = 1'b0;
    tn_o = 1'b0;
    case ({month_ten_i, month_unit_i})
      MON_FEB: begin
        to_o = 1'b0;
        tn_o = 1'b1;
      end
      5'h04, 5'h06, 5'h09, 5'h11: begin
        to_o = 1'b0;
        t_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Divisible-by-4 test on a BCD pair: the unit set depends on ten parity.
  always_comb begin
    if (year_ten_i[0])
      leap_o = (year_unit_i == 4'd2) || (year_unit_i == 4'd6);
    else
      leap_o = (year_unit_i == 4'd0) || (year_unit_i == 4'd4) || (year_unit_i == 4'd8);
  end

  always_comb begin
    if (to_o)        maxday_o = MAXDAY_31;
    else if (t_o)    maxday_o = MAXDAY_30;
    else if (leap_o) maxday_o = MAXDAY_29;
    else             maxday_o = MAXDAY_28;
  end

endmodule

// File: rtl/calendar_ctrl.sv
// Calendar controller: owns the BCD month and year counters and the
// user set-mode FSM, and sequences the external day counter.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - calendar_ctrl_if.master: tick_day, pulse_d, buttons and day
//           digits in; en_d/up/down, TO/T/TN/leap_year, month/year digits,
//           mode and pulse_y out.
// Parameters: RESET_MONTH (1-12), RESET_YEAR (0-99), binary, stored as BCD.
// Optional build macro CAL_TICK_HOLD_EN: a day tick arriving outside RUN is
// held (one deep) and delivered on the first RUN cycle instead of dropped.
module calendar_ctrl
  import cal_pkg::*;
#(
  parameter int unsigned RESET_MONTH = 1,
  parameter int unsigned RESET_YEAR  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  calendar_ctrl_if.master bus
);

  localparam logic [7:0] RST_MONTH_BCD = bin2bcd(RESET_MONTH);
  localparam logic [7:0] RST_YEAR_BCD  = bin2bcd(RESET_YEAR);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [4:0] month_q, month_d;
  logic [7:0] year_q, year_d;
  logic       pulse_y_q, pulse_y_d;

  logic       en_c, up_c, down_c;
  logic       to_w, t_w, tn_w, leap_w;
  logic [5:0] maxday_w;
  logic [5:0] day_bin;
  logic       tick_w;

  assign day_bin = ({4'b0, bus.day_ten} * 6'd10) + {2'b0, bus.day_unit};

  cal_decode u_decode (
    .month_unit_i (month_q[3:0]),
    .month_ten_i  (month_q[4]),
    .year_unit_i  (year_q[3:0]),
    .year_ten_i   (year_q[7:4]),
    .to_o         (to_w),
    .t_o          (t_w),
    .tn_o         (tn_w),
    .leap_o       (leap_w),
    .maxday_o     (maxday_w)
  );

`ifdef CAL_TICK_HOLD_EN
  logic pend_q, pend_d;

  // In RUN a held tick goes out first; a live tick in that same cycle
  // re-arms the flag so it is delivered one cycle later.
  always_comb begin
    pend_d = pend_q;
    tick_w = bus.tick_day;
    if (state_q == ST_RUN) begin
      tick_w = pend_q | bus.tick_day;
      pend_d = pend_q & bus.tick_day;
    end else begin
      pend_d = pend_q | bus.tick_day;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end
`else
  assign tick_w = bus.tick_day;
`endif

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    month_d   = month_q;
    year_d    = year_q;
    pulse_y_d = 1'b0;
    en_c      = 1'b0;
    up_c      = 1'b0;
    down_c    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        en_c = tick_w;
        if (bus.pulse_d) begin
          month_d = month_inc(month_q);
          if (month_q == MON_DEC) begin
            year_d    = year_inc(year_q);
            pulse_y_d = (year_q == 8'h99);
          end
        end
        if (bus.btn_mode) state_d = ST_SET_DAY;
      end
      ST_SET_DAY: begin
        if (bus.btn_mode) begin
          state_d = ST_SET_MONTH;
        end else begin
          up_c   = bus.btn_up & ~bus.btn_down;
          down_c = bus.btn_down & ~bus.btn_up;
        end
      end
      ST_SET_MONTH: begin
        if (bus.btn_mode) begin
          state_d = ST_SET_YEAR;
        end else if (bus.btn_up ^ bus.btn_down) begin
          month_d = bus.btn_up ? month_inc(month_q) : month_dec(month_q);
          ret_d   = ST_SET_MONTH;
          state_d = ST_CLAMP_CHK;
        end
      end
      ST_SET_YEAR: begin
        if (bus.btn_mode) begin
          state_d = ST_RUN;
        end else if (bus.btn_up ^ bus.btn_down) begin
          year_d  = bus.btn_up ? year_inc(year_q) : year_dec(year_q);
          ret_d   = ST_SET_YEAR;
          state_d = ST_CLAMP_CHK;
        end
      end
      // One down step per check; the wait cycle lets the day counter settle
      // before the next comparison.
      ST_CLAMP_CHK: begin
        if (day_bin > maxday_w) begin
          down_c  = 1'b1;
          state_d = ST_CLAMP_WAIT;
        end else begin
          state_d = ret_q;
        end
      end
      ST_CLAMP_WAIT: state_d = ST_CLAMP_CHK;
      default:       state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_SET_MONTH;
      month_q   <= RST_MONTH_BCD[4:0];
      year_q    <= RST_YEAR_BCD;
      pulse_y_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      month_q   <= month_d;
      year_q    <= year_d;
      pulse_y_q <= pulse_y_d;
    end
  end

  // Clamp states report the set mode they will return to.
  always_comb begin
    unique case (state_q)
      ST_RUN:       bus.mode = MODE_RUN;
      ST_SET_DAY:   bus.mode = MODE_SET_DAY;
      ST_SET_MONTH: bus.mode = MODE_SET_MONTH;
      ST_SET_YEAR:  bus.mode = MODE_SET_YEAR;
      default:      bus.mode = (ret_q == ST_SET_YEAR) ? MODE_SET_YEAR : MODE_SET_MONTH;
    endcase
  end

  assign bus.en_d       = en_c;
  assign bus.up         = up_c;
  assign bus.down       = down_c;
  assign bus.TO         = to_w;
  assign bus.T          = t_w;
  assign bus.TN         = tn_w;
  assign bus.leap_year  = leap_w;
  assign bus.month_unit = month_q[3:0];
  assign bus.month_ten  = month_q[4];
  assign bus.year_unit  = year_q[3:0];
  assign bus.year_ten   = year_q[7:4];
  assign bus.pulse_y    = pulse_y_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
module tb_calendar_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   day = 1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  calendar_ctrl_if bus ();

  calendar_ctrl #(.RESET_MONTH(1), .RESET_YEAR(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Day counter stand-in: the bench owns the day value.
  assign bus.day_unit = 4'(day % 10);
  assign bus.day_ten  = 2'(day / 10);

  // Stimulus {tick_day, pulse_d, btn_mode, btn_up, btn_down}
  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_TICK = 5'b10000;
  localparam logic [4:0] S_PD   = 5'b01000;
  localparam logic [4:0] S_MODE = 5'b00100;
  localparam logic [4:0] S_UP   = 5'b00010;
  localparam logic [4:0] S_DN   = 5'b00001;
  // Pulses {en_d, up, down, pulse_y}
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_EN   = 4'b1000;
  localparam logic [3:0] P_UP   = 4'b0100;
  localparam logic [3:0] P_DN   = 4'b0010;
  localparam logic [3:0] P_PY   = 4'b0001;
`ifdef CAL_TICK_HOLD_EN
  localparam logic [3:0] P_HOLD = 4'b1000;
`else
  localparam logic [3:0] P_HOLD = 4'b0000;
`endif
  // Decode {TO, T, TN, leap_year}
  localparam logic [3:0] D_TO = 4'b1000;
  localparam logic [3:0] D_T  = 4'b0100;
  localparam logic [3:0] D_TN = 4'b0010;
  localparam logic [3:0] D_L  = 4'b0001;

  typedef struct {
    string       nm;
    logic [4:0]  stim;
    logic [22:0] exp;
  } item_t;

  item_t sbq[$];
  item_t it;
  logic  dn_seen;

  function automatic logic [22:0] ev(input logic [3:0] p, input logic [1:0] m,
                                     input logic [7:0] mon, input logic [7:0] yr,
                                     input logic [3:0] d);
    return {p, m, mon[4:0], yr, d};
  endfunction

  function automatic logic [22:0] obs();
    return {bus.en_d, bus.up, bus.down, bus.pulse_y, bus.mode, bus.month_ten,
            bus.month_unit, bus.year_ten, bus.year_unit, bus.TO, bus.T, bus.TN,
            bus.leap_year};
  endfunction

  function automatic void push(input string nm, input logic [4:0] s, input logic [22:0] e);
    item_t x;
    x.nm = nm;
    x.stim = s;
    x.exp = e;
    sbq.push_back(x);
  endfunction

  task automatic set_stim(input logic [4:0] s);
    {bus.tick_day, bus.pulse_d, bus.btn_mode, bus.btn_up, bus.btn_down} = s;
  endtask

  // One unchecked cycle of stimulus; a down pulse lowers the bench day.
  task automatic drive(input logic [4:0] s);
    logic d;
    set_stim(s);
    @(negedge clk);
    d = bus.down;
    @(posedge clk);
    #1;
    if (d) day = day - 1;
    set_stim(S_IDLE);
  endtask

  task automatic press_n(input logic [4:0] s, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive(s);
      drive(S_IDLE);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(S_IDLE);
    drive(S_IDLE);
    rst_n = 1'b1;
    push("reset",    S_IDLE, ev(P_NONE, 2'd0, 8'h01, 8'h00, D_TO | D_L));
    push("run_tick", S_TICK, ev(P_EN,   2'd0, 8'h01, 8'h00, D_TO | D_L));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      set_stim(it.stim);
      @(negedge clk);
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", it.nm, obs(), it.exp);
      end
      dn_seen = bus.down;
      @(posedge clk);
      #1;
      if (dn_seen) day = day - 1;
      set_stim(S_IDLE);
    end
  endtask

  task automatic test_month_roll();
    day = 1;
    drive(S_MODE);
    drive(S_MODE);
    press_n(S_UP, 1);
    drive(S_MODE);
    press_n(S_UP, 23);
    drive(S_MODE);
    day = 28;
    push("feb23",   S_IDLE,        ev(P_NONE, 2'd0, 8'h02, 8'h23, D_TN));
    push("tick_pd", S_TICK | S_PD, ev(P_EN,   2'd0, 8'h02, 8'h23, D_TN));
    push("mar23",   S_PD,          ev(P_NONE, 2'd0, 8'h03, 8'h23, D_TO));
    push("apr23",   S_IDLE,        ev(P_NONE, 2'd0, 8'h04, 8'h23, D_T));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      set_stim(it.stim);
      @(negedge clk);
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", it.nm, obs(), it.exp);
      end
      dn_seen = bus.down;
      @(posedge clk);
      #1;
      if (dn_seen) day = day - 1;
      set_stim(S_IDLE);
    end
  endtask

  task automatic test_century();
    rst_n = 1'b0;
    drive(S_IDLE);
    rst_n = 1'b1;
    day = 1;
    drive(S_MODE);
    drive(S_MODE);
    push("m_dn_wrap", S_DN,          ev(P_NONE, 2'd2, 8'h01, 8'h00, D_TO | D_L));
    push("m12_chk",   S_IDLE,        ev(P_NONE, 2'd2, 8'h12, 8'h00, D_TO | D_L));
    push("m12",       S_MODE,        ev(P_NONE, 2'd2, 8'h12, 8'h00, D_TO | D_L));
    push("y_dn_wrap", S_DN,          ev(P_NONE, 2'd3, 8'h12, 8'h00, D_TO | D_L));
    push("y99_chk",   S_IDLE,        ev(P_NONE, 2'd3, 8'h12, 8'h99, D_TO));
    push("y99",       S_MODE,        ev(P_NONE, 2'd3, 8'h12, 8'h99, D_TO));
    push("run_dec",   S_TICK | S_PD, ev(P_EN,   2'd0, 8'h12, 8'h99, D_TO));
    push("century",   S_IDLE,        ev(P_PY,   2'd0, 8'h01, 8'h00, D_TO | D_L));
    push("py_once",   S_IDLE,        ev(P_NONE, 2'd0, 8'h01, 8'h00, D_TO | D_L));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      set_stim(it.stim);
      @(negedge clk);
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", it.nm, obs(), it.exp);
      end
      dn_seen = bus.down;
      @(posedge clk);
      #1;
      if (dn_seen) day = day - 1;
      set_stim(S_IDLE);
    end
  endtask

  task automatic test_clamp_month();
    rst_n = 1'b0;
    drive(S_IDLE);
    rst_n = 1'b1;
    day = 1;
    drive(S_MODE);
    drive(S_MODE);
    drive(S_MODE);
    press_n(S_UP, 21);
    drive(S_MODE);
    drive(S_MODE);
    drive(S_MODE);
    day = 31;
    push("m_up",    S_IDLE | S_UP, ev(P_NONE, 2'd2, 8'h01, 8'h21, D_TO));
    push("cl1",     S_IDLE,        ev(P_DN,   2'd2, 8'h02, 8'h21, D_TN));
    push("cl2",     S_UP,          ev(P_NONE, 2'd2, 8'h02, 8'h21, D_TN));
    push("cl3",     S_IDLE,        ev(P_DN,   2'd2, 8'h02, 8'h21, D_TN));
    push("cl4",     S_MODE,        ev(P_NONE, 2'd2, 8'h02, 8'h21, D_TN));
    push("cl5",     S_IDLE,        ev(P_DN,   2'd2, 8'h02, 8'h21, D_TN));
    push("cl6",     S_IDLE,        ev(P_NONE, 2'd2, 8'h02, 8'h21, D_TN));
    push("cl7",     S_IDLE,        ev(P_NONE, 2'd2, 8'h02, 8'h21, D_TN));
    push("cl_back", S_MODE,        ev(P_NONE, 2'd2, 8'h02, 8'h21, D_TN));
    push("to_year", S_IDLE,        ev(P_NONE, 2'd3, 8'h02, 8'h21, D_TN));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      set_stim(it.stim);
      @(negedge clk);
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", it.nm, obs(), it.exp);
      end
      dn_seen = bus.down;
      @(posedge clk);
      #1;
      if (dn_seen) day = day - 1;
      set_stim(S_IDLE);
    end
    checks++;
    if (day !== 28) begin
      errors++;
      $display("FAIL clamp_day: observed %0d expected 28", day);
    end
  endtask

  task automatic test_clamp_year();
    press_n(S_UP, 3);
    day = 29;
    push("y24",    S_IDLE,        ev(P_NONE, 2'd3, 8'h02, 8'h24, D_TN | D_L));
    push("y_up",   S_UP,          ev(P_NONE, 2'd3, 8'h02, 8'h24, D_TN | D_L));
    push("cy1",    S_IDLE,        ev(P_DN,   2'd3, 8'h02, 8'h25, D_TN));
    push("cy2",    S_IDLE,        ev(P_NONE, 2'd3, 8'h02, 8'h25, D_TN));
    push("cy3",    S_IDLE,        ev(P_NONE, 2'd3, 8'h02, 8'h25, D_TN));
    push("y_both", S_UP | S_DN,   ev(P_NONE, 2'd3, 8'h02, 8'h25, D_TN));
    push("y_hold", S_IDLE,        ev(P_NONE, 2'd3, 8'h02, 8'h25, D_TN));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      set_stim(it.stim);
      @(negedge clk);
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", it.nm, obs(), it.exp);
      end
      dn_seen = bus.down;
      @(posedge clk);
      #1;
      if (dn_seen) day = day - 1;
      set_stim(S_IDLE);
    end
  endtask

  task automatic test_set_day();
    drive(S_MODE);
    drive(S_MODE);
    push("sd_up",      S_UP,          ev(P_UP,   2'd1, 8'h02, 8'h25, D_TN));
    push("sd_dn",      S_DN,          ev(P_DN,   2'd1, 8'h02, 8'h25, D_TN));
    push("sd_both",    S_UP | S_DN,   ev(P_NONE, 2'd1, 8'h02, 8'h25, D_TN));
    push("sd_tick",    S_TICK,        ev(P_NONE, 2'd1, 8'h02, 8'h25, D_TN));
    push("sd_mode_up", S_MODE | S_UP, ev(P_NONE, 2'd1, 8'h02, 8'h25, D_TN));
    push("sd_to_mon",  S_IDLE,        ev(P_NONE, 2'd2, 8'h02, 8'h25, D_TN));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      set_stim(it.stim);
      @(negedge clk);
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", it.nm, obs(), it.exp);
      end
      dn_seen = bus.down;
      @(posedge clk);
      #1;
      if (dn_seen) day = day - 1;
      set_stim(S_IDLE);
    end
  endtask

  task automatic test_tick_hold();
    drive(S_MODE);
    push("sy_tick",    S_TICK,          ev(P_NONE, 2'd3, 8'h02, 8'h25, D_TN));
    push("sy_mode",    S_MODE,          ev(P_NONE, 2'd3, 8'h02, 8'h25, D_TN));
    push("run_first",  S_IDLE,          ev(P_HOLD, 2'd0, 8'h02, 8'h25, D_TN));
    push("run_second", S_IDLE,          ev(P_NONE, 2'd0, 8'h02, 8'h25, D_TN));
    push("r_mode",     S_MODE,          ev(P_NONE, 2'd0, 8'h02, 8'h25, D_TN));
    push("sd_tick2",   S_TICK | S_MODE, ev(P_NONE, 2'd1, 8'h02, 8'h25, D_TN));
    push("sm",         S_MODE,          ev(P_NONE, 2'd2, 8'h02, 8'h25, D_TN));
    push("sy",         S_MODE,          ev(P_NONE, 2'd3, 8'h02, 8'h25, D_TN));
    push("run_a",      S_TICK,          ev(P_EN,   2'd0, 8'h02, 8'h25, D_TN));
    push("run_b",      S_IDLE,          ev(P_HOLD, 2'd0, 8'h02, 8'h25, D_TN));
    push("run_c",      S_IDLE,          ev(P_NONE, 2'd0, 8'h02, 8'h25, D_TN));
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      set_stim(it.stim);
      @(negedge clk);
      checks++;
      if (obs() !== it.exp) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", it.nm, obs(), it.exp);
      end
      dn_seen = bus.down;
      @(posedge clk);
      #1;
      if (dn_seen) day = day - 1;
      set_stim(S_IDLE);
    end
  endtask

  initial begin
    set_stim(S_IDLE);
    @(posedge clk);
    #1;
    test_reset();
    test_month_roll();
    test_century();
    test_clamp_month();
    test_clamp_year();
    test_set_day();
    test_tick_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
